// File: rtl/fetch_stage_pkg.sv
// Shared bus-length header for the IF/ID boundary; decode imports the same constants.
package fetch_stage_pkg;

    localparam int unsigned FS2DS_BUS_LEN    = 64;
    localparam int unsigned BR_BUS_LEN       = 33;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fs2ds_bus_t;

    // Sequential successor of a PC, wrapping at 32 bits.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary: fs2ds stream to decode, redirect bus from decode, instruction SRAM port.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic                     ds_allowin;
    logic                     fs2ds_valid;
    logic [FS2DS_BUS_LEN-1:0] fs2ds_bus;
    logic [BR_BUS_LEN-1:0]    br_zip;
    logic                     inst_sram_en;
    logic [3:0]               inst_sram_we;
    logic [31:0]              inst_sram_addr;
    logic [31:0]              inst_sram_wdata;
    logic [31:0]              inst_sram_rdata;

    // Fetch-stage side.
    modport master (
        input  ds_allowin, br_zip, inst_sram_rdata,
        output fs2ds_valid, fs2ds_bus, inst_sram_en, inst_sram_we,
               inst_sram_addr, inst_sram_wdata
    );

    // Decode / SRAM side.
    modport slave (
        output ds_allowin, br_zip, inst_sram_rdata,
        input  fs2ds_valid, fs2ds_bus, inst_sram_en, inst_sram_we,
               inst_sram_addr, inst_sram_wdata
    );

endinterface

// File: rtl/fetch_inst_buf.sv
// One-entry skid register holding the SRAM word while decode back-pressures IF.
module fetch_inst_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_valid_i,
    input  logic        ds_allowin_i,
    input  logic        br_taken_i,
    input  logic        fs_allowin_i,
    input  logic [31:0] sram_rdata_i,
    output logic [31:0] inst_o
);

    logic        buf_valid_q, buf_valid_d;
    logic [31:0] inst_buf_q,  inst_buf_d;
    logic        capture;

    // Capture only implies fs_allowin=0, so it never collides with a clear.
    assign capture = fs_valid_i & ~buf_valid_q & ~ds_allowin_i & ~br_taken_i;

    // Next-state: clear on any IF advance, capture on first stalled cycle.
    always_comb begin
        buf_valid_d = buf_valid_q;
        inst_buf_d  = inst_buf_q;
        if (fs_allowin_i) begin
            buf_valid_d = 1'b0;
        end else if (capture) begin
            buf_valid_d = 1'b1;
            inst_buf_d  = sram_rdata_i;
        end
    end

    // Buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            inst_buf_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            inst_buf_q  <= inst_buf_d;
        end
    end

    // Buffered word takes precedence over the live SRAM output.
    always_comb begin
        inst_o = buf_valid_q ? inst_buf_q : sram_rdata_i;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues pre-IF SRAM reads, feeds decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master fs
);

    br_bus_t     br;
    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q,    fs_pc_d;
    logic [31:0] nextpc;
    logic        to_fs_valid;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic [31:0] inst;

    assign br          = br_bus_t'(fs.br_zip);
    assign fs_ready_go = 1'b1;
    assign to_fs_valid = ~reset;

    // Pre-IF address selection and IF handshake; a redirect forces allowin.
    always_comb begin
        nextpc      = br.taken ? br.target : seq_pc(fs_pc_q);
        fs_allowin  = ~fs_valid_q | (fs_ready_go & fs.ds_allowin) | br.taken;
        fs_valid_d  = fs_valid_q;
        fs_pc_d     = fs_pc_q;
        if (fs_allowin) begin
            fs_valid_d = to_fs_valid;
            fs_pc_d    = nextpc;
        end
    end

    // PC and valid registers; the reset PC sits one word before the first fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_q <= 1'b0;
            fs_pc_q    <= RESET_PC - 32'd4;
        end else begin
            fs_valid_q <= fs_valid_d;
            fs_pc_q    <= fs_pc_d;
        end
    end

    fetch_inst_buf u_inst_buf (
        .clk          (clk),
        .reset        (reset),
        .fs_valid_i   (fs_valid_q),
        .ds_allowin_i (fs.ds_allowin),
        .br_taken_i   (br.taken),
        .fs_allowin_i (fs_allowin),
        .sram_rdata_i (fs.inst_sram_rdata),
        .inst_o       (inst)
    );

    // Outputs to decode and the instruction SRAM; wrong-path word is masked on redirect.
    always_comb begin
        fs.fs2ds_valid     = fs_valid_q & fs_ready_go & ~br.taken;
        fs.fs2ds_bus       = fs2ds_bus_t'{pc: fs_pc_q, inst: inst};
        fs.inst_sram_en    = to_fs_valid & fs_allowin;
        fs.inst_sram_we    = '0;
        fs.inst_sram_addr  = nextpc;
        fs.inst_sram_wdata = '0;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic reset;
    logic x_mode = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_stage_if fsif();

    fetch_stage #(.RESET_PC(32'h1c00_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .fs    (fsif)
    );

    // SRAM model: one-cycle read latency, data = addr ^ K; optionally goes X when idle.
    always @(posedge clk) begin
        if (fsif.inst_sram_en === 1'b1)
            fsif.inst_sram_rdata <= fsif.inst_sram_addr ^ K;
        else if (x_mode)
            fsif.inst_sram_rdata <= 'x;
    end

    function automatic logic [63:0] word(input logic [31:0] pc);
        return {pc, pc ^ K};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every word decode accepts must be the next expected one.
    always @(negedge clk) begin
        if (fsif.fs2ds_valid === 1'b1 && fsif.ds_allowin === 1'b1) begin
            if (exp_q.size() == 0)
                check("xfer_when_empty", 64'(exp_q.size()), 64'd1);
            else
                check("xfer", fsif.fs2ds_bus, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        fsif.ds_allowin = 1'b1;
        fsif.br_zip = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_en",    64'(fsif.inst_sram_en), 64'd0);
        check("rst_valid", 64'(fsif.fs2ds_valid),  64'd0);
        check("rst_addr",  64'(fsif.inst_sram_addr), 64'h1c00_0000);
        check("rst_we",    64'(fsif.inst_sram_we), 64'd0);
        check("rst_wdata", 64'(fsif.inst_sram_wdata), 64'd0);

        // Reset release, sequential fetch
        next_cycle(); reset = 1'b0;
        exp_q.push_back(word(32'h1c00_0000));
        exp_q.push_back(word(32'h1c00_0004));
        exp_q.push_back(word(32'h1c00_0008));
        @(negedge clk);
        check("c0_en",    64'(fsif.inst_sram_en), 64'd1);
        check("c0_addr",  64'(fsif.inst_sram_addr), 64'h1c00_0000);
        check("c0_valid", 64'(fsif.fs2ds_valid), 64'd0);
        next_cycle(); @(negedge clk);
        check("c1_valid", 64'(fsif.fs2ds_valid), 64'd1);
        check("c1_bus",   fsif.fs2ds_bus, 64'h1c00_0000_b9a5_0000);
        check("c1_addr",  64'(fsif.inst_sram_addr), 64'h1c00_0004);
        next_cycle(); @(negedge clk);
        check("c2_addr",  64'(fsif.inst_sram_addr), 64'h1c00_0008);

        // Three-cycle decode stall with SRAM going X
        next_cycle(); fsif.ds_allowin = 1'b0; x_mode = 1'b1;
        @(negedge clk);
        check("stall0_en",  64'(fsif.inst_sram_en), 64'd0);
        check("stall0_bus", fsif.fs2ds_bus, word(32'h1c00_0008));
        repeat (2) begin
            next_cycle(); @(negedge clk);
            check("stall_en",    64'(fsif.inst_sram_en), 64'd0);
            check("stall_valid", 64'(fsif.fs2ds_valid), 64'd1);
            check("stall_bus",   fsif.fs2ds_bus, word(32'h1c00_0008));
        end
        next_cycle(); fsif.ds_allowin = 1'b1; x_mode = 1'b0;
        @(negedge clk);
        check("rel_en",   64'(fsif.inst_sram_en), 64'd1);
        check("rel_addr", 64'(fsif.inst_sram_addr), 64'h1c00_000c);

        // Redirect while IF holds 1c00000c
        next_cycle(); fsif.br_zip = {1'b1, 32'h1c00_0100};
        exp_q.push_back(word(32'h1c00_0100));
        @(negedge clk);
        check("br_valid", 64'(fsif.fs2ds_valid), 64'd0);
        check("br_en",    64'(fsif.inst_sram_en), 64'd1);
        check("br_addr",  64'(fsif.inst_sram_addr), 64'h1c00_0100);
        next_cycle(); fsif.br_zip = '0;
        @(negedge clk);
        check("br_next_addr", 64'(fsif.inst_sram_addr), 64'h1c00_0104);

        // Redirect while the buffer is occupied
        next_cycle(); fsif.ds_allowin = 1'b0;
        @(negedge clk);
        check("bstall_en", 64'(fsif.inst_sram_en), 64'd0);
        next_cycle(); fsif.br_zip = {1'b1, 32'h1c00_0200};
        exp_q.push_back(word(32'h1c00_0200));
        @(negedge clk);
        check("bbr_valid", 64'(fsif.fs2ds_valid), 64'd0);
        check("bbr_en",    64'(fsif.inst_sram_en), 64'd1);
        check("bbr_addr",  64'(fsif.inst_sram_addr), 64'h1c00_0200);
        next_cycle(); fsif.br_zip = '0; fsif.ds_allowin = 1'b1;
        @(negedge clk);
        check("bbr_next_addr", 64'(fsif.inst_sram_addr), 64'h1c00_0204);

        // Redirect to 1c000040, then reset mid-stream (with a redirect during reset)
        next_cycle(); fsif.br_zip = {1'b1, 32'h1c00_0040};
        @(negedge clk);
        check("br40_valid", 64'(fsif.fs2ds_valid), 64'd0);
        check("br40_addr",  64'(fsif.inst_sram_addr), 64'h1c00_0040);
        next_cycle(); fsif.br_zip = '0; reset = 1'b1; fsif.ds_allowin = 1'b0;
        @(negedge clk);
        check("mrst_en", 64'(fsif.inst_sram_en), 64'd0);
        next_cycle(); fsif.br_zip = {1'b1, 32'h1c00_0300};
        @(negedge clk);
        check("mrst1_valid", 64'(fsif.fs2ds_valid), 64'd0);
        check("mrst1_en",    64'(fsif.inst_sram_en), 64'd0);
        next_cycle(); reset = 1'b0; fsif.br_zip = '0; fsif.ds_allowin = 1'b1;
        exp_q.push_back(word(32'h1c00_0000));
        @(negedge clk);
        check("mrel_en",    64'(fsif.inst_sram_en), 64'd1);
        check("mrel_addr",  64'(fsif.inst_sram_addr), 64'h1c00_0000);
        check("mrel_valid", 64'(fsif.fs2ds_valid), 64'd0);
        next_cycle(); @(negedge clk);
        check("mrel_next_addr", 64'(fsif.inst_sram_addr), 64'h1c00_0004);

        // PC wrap from ffff_fffc
        next_cycle(); fsif.br_zip = {1'b1, 32'hffff_fffc};
        exp_q.push_back(word(32'hffff_fffc));
        exp_q.push_back(word(32'h0000_0000));
        @(negedge clk);
        check("wbr_valid", 64'(fsif.fs2ds_valid), 64'd0);
        check("wbr_addr",  64'(fsif.inst_sram_addr), 64'hffff_fffc);
        next_cycle(); fsif.br_zip = '0;
        @(negedge clk);
        check("wrap_addr", 64'(fsif.inst_sram_addr), 64'h0000_0000);
        check("wrap_en",   64'(fsif.inst_sram_en), 64'd1);
        next_cycle(); @(negedge clk);
        check("wrap_next_addr", 64'(fsif.inst_sram_addr), 64'h0000_0004);
        next_cycle(); fsif.ds_allowin = 1'b0;
        @(negedge clk);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
